// File: rtl/hap_pkg.sv
// Shared definitions for the Harvard processor: default widths, reset PC,
// control-flow opcodes and the fetch state encoding.
package hap_pkg;
  localparam int          DEF_ADDR_W   = 8;
  localparam int          DEF_INSTR_W  = 16;
  localparam logic [7:0]  DEF_RESET_PC = 8'h00;

  localparam logic [4:0] OP_BNE = 5'h10;
  localparam logic [4:0] OP_BEQ = 5'h11;
  localparam logic [4:0] OP_JMP = 5'h12;
  localparam logic [4:0] OP_JAL = 5'h13;
  localparam logic [4:0] OP_JR  = 5'h14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, downstream valid/ready, redirect.
interface instr_fetch_if
  import hap_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  npc;
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, npc,
    input  imem_ack, imem_rdata, instr_ready, redir_valid, redir_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, npc,
    output imem_ack, imem_rdata, instr_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC select: redirect target wins, otherwise pc or pc+1 (wraps mod 2^ADDR_W).
module pc_next
  import hap_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              inc,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] pc_nxt
);
  assign pc_inc = pc + ADDR_W'(1);
  assign pc_nxt = redir_valid ? redir_pc : (inc ? pc_inc : pc);
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues imem reads and presents {instr, npc}
// downstream; redirects discard any wrong-path fetch in flight or held.
module instr_fetch
  import hap_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, addr_q, addr_d, npc_q, npc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               req_q, req_d, valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_inc, pc_nxt;
  logic               inc;

  assign inc = (state_q == REQ) && bus.imem_ack && !bus.redir_valid;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc          (pc_q),
    .inc         (inc),
    .redir_valid (bus.redir_valid),
    .redir_pc    (bus.redir_pc),
    .pc_inc      (pc_inc),
    .pc_nxt      (pc_nxt)
  );

  // pc follows pc_nxt in every state; only REQ+ack advances it by one.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_nxt;
    addr_d  = addr_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_nxt;
      end
      REQ: begin
        if (bus.redir_valid) begin
          if (bus.imem_ack) addr_d = pc_nxt;
          else              state_d = DROP;
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          npc_d   = pc_inc;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          addr_d  = pc_nxt;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (bus.redir_valid || bus.instr_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_nxt;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      npc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.npc         = npc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table of directed corner cases, then a random
// run checked against an expected-PC stream model with a wait-state memory.
module tb_instr_fetch;
  import hap_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [256];

  typedef struct {
    logic ack, rdy, rv; logic [7:0] rpc;
    logic e_req; logic [7:0] e_addr; logic e_valid; logic [15:0] e_instr; logic [7:0] e_npc;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(logic ack, logic rdy, logic rv, logic [7:0] rpc, logic er,
                             logic [7:0] ea, logic ev, logic [15:0] ei, logic [7:0] en);
    vec_t r;
    r.ack = ack; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.e_req = er; r.e_addr = ea; r.e_valid = ev; r.e_instr = ei; r.e_npc = en;
    return r;
  endfunction

  task automatic drive(input logic ack, input logic rdy, input logic rv, input logic [7:0] rpc);
    bus.imem_ack    = ack;
    bus.imem_rdata  = ack ? mem[bus.imem_addr] : 16'hDEAD;
    bus.instr_ready = rdy;
    bus.redir_valid = rv;
    bus.redir_pc    = rpc;
  endtask

  initial begin
    logic [7:0]  exp_pc, prev_addr;
    logic        prev_req, prev_ack, ack, rdy, rv;
    logic [7:0]  rpc;
    int          wcnt, idle, xfers;

    for (int k = 0; k < 256; k++) mem[k] = 16'hA000 + 16'(k);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    //   ack rdy rv rpc    req addr  vld instr     npc
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00, 0,16'h0000,8'h00)); // IDLE
    tbl.push_back(v(1,1,0,8'h00, 1,8'h00, 0,16'h0000,8'h00));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00, 1,16'hA000,8'h01));
    tbl.push_back(v(1,1,0,8'h00, 1,8'h01, 0,16'h0000,8'h00));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00, 1,16'hA001,8'h02));
    tbl.push_back(v(1,1,0,8'h00, 1,8'h02, 0,16'h0000,8'h00));
    tbl.push_back(v(1,0,0,8'h00, 0,8'h00, 1,16'hA002,8'h03)); // stray ack in HOLD
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0,0,0,8'h00, 0,8'h00, 1,16'hA002,8'h03));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00, 1,16'hA002,8'h03));
    tbl.push_back(v(0,0,1,8'h10, 1,8'h03, 0,16'h0000,8'h00)); // redir -> DROP
    tbl.push_back(v(1,0,0,8'h00, 1,8'h03, 0,16'h0000,8'h00));
    tbl.push_back(v(0,0,0,8'h00, 1,8'h10, 0,16'h0000,8'h00));
    tbl.push_back(v(0,0,1,8'h40, 1,8'h10, 0,16'h0000,8'h00)); // redir mid-wait
    tbl.push_back(v(0,0,0,8'h00, 1,8'h10, 0,16'h0000,8'h00));
    tbl.push_back(v(1,0,0,8'h00, 1,8'h10, 0,16'h0000,8'h00));
    tbl.push_back(v(1,0,0,8'h00, 1,8'h40, 0,16'h0000,8'h00));
    tbl.push_back(v(1,1,1,8'h20, 0,8'h00, 1,16'hA040,8'h41)); // redir+ready+ack in HOLD
    tbl.push_back(v(1,0,1,8'hFF, 1,8'h20, 0,16'h0000,8'h00)); // redir+ack in REQ
    tbl.push_back(v(1,0,0,8'h00, 1,8'hFF, 0,16'h0000,8'h00));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00, 1,16'hA0FF,8'h00)); // wrap
    tbl.push_back(v(1,1,0,8'h00, 1,8'h00, 0,16'h0000,8'h00));
    tbl.push_back(v(0,1,0,8'h00, 0,8'h00, 1,16'hA000,8'h01));
    tbl.push_back(v(0,0,0,8'h00, 1,8'h01, 0,16'h0000,8'h00));

    repeat (2) @(negedge clk);
    check("reset_state", {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.npc},
          {1'b0, 8'h00, 1'b0, 16'h0000, 8'h00});
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      check($sformatf("vec%0d", i),
            {bus.imem_req, tbl[i].e_req ? bus.imem_addr : 8'h00, bus.instr_valid,
             tbl[i].e_valid ? bus.instr : 16'h0000, tbl[i].e_valid ? bus.npc : 8'h00},
            {tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_npc});
      drive(tbl[i].ack, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      @(negedge clk);
    end

    // Reset asserted while a request is outstanding takes effect without a clock.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.imem_req, bus.instr_valid, bus.imem_addr}, {1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_after_reset", {bus.imem_req, bus.instr_valid}, {1'b0, 1'b0});
    @(negedge clk);
    check("first_req", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h00});

    // Random run: every accepted instr must be mem[expected pc] with npc = pc+1.
    rst_n = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 8'h00; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 8'h00;
    wcnt = $urandom_range(0, 3); idle = 0; xfers = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_req && !prev_ack)
        check("req_stable", {bus.imem_req, bus.imem_addr}, {1'b1, prev_addr});
      rdy = ($urandom_range(0, 3) != 0);
      rv  = (cyc > 2) && ($urandom_range(0, 11) == 0);
      rpc = 8'($urandom);
      ack = 1'b0;
      if (bus.imem_req) begin
        if (wcnt == 0) begin
          ack  = 1'b1;
          wcnt = $urandom_range(0, 3);
        end else wcnt--;
      end
      if (bus.instr_valid && rdy) begin
        check("xfer", {bus.instr, bus.npc}, {mem[exp_pc], exp_pc + 8'd1});
        exp_pc = exp_pc + 8'd1;
        xfers++;
        idle = 0;
      end else idle++;
      if (rv) exp_pc = rpc;
      if (idle > 200) begin
        errors++;
        $display("FAIL stall: no transfer for %0d cycles, required at most 200", idle);
        break;
      end
      prev_req = bus.imem_req; prev_ack = ack; prev_addr = bus.imem_addr;
      drive(ack, rdy, rv, rpc);
      @(negedge clk);
    end
    checks++;
    if (xfers < 200) begin
      errors++;
      $display("FAIL throughput: got %0d transfers, required at least 200", xfers);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
